sd_boot_loader: RTL and testbench
=================================

# sd_boot_loader

Sequencer that drives the SD-card byte-read controller to copy a fixed run of 512-byte sectors into word-addressed program memory at power-up or on request. It issues one sector read at a time and packs the byte stream big-endian into 32-bit words. Each word goes out as a one-cycle memory write strobe. It sits between `sd_controller` (read side only; write side unused) and the instruction-memory write port, and holds the CPU in reset via `busy`.

## Interface
Parameters:
- `SECTOR_COUNT`, default 8: number of consecutive sectors copied per run (1..2^16-1).
- `BASE_SECTOR`, default 0: first SD sector index; byte address = sector index × 512.
- `MEM_ADDR_W`, default 12: width of the memory word address.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to begin a copy run; ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` until the run ends.
- `done` out 1: sticky; set when the last word is written, cleared by the next accepted `start` or by reset.
- `sd_ready` in 1: controller idle and able to accept `sd_rd`.
- `sd_rd` out 1: one-cycle read request to the controller.
- `sd_address` out 32: sector byte address, always a multiple of 512.
- `sd_dout` in 8: byte from the controller.
- `sd_byte_available` in 1: `sd_dout` is valid this cycle; each high cycle is one byte.
- `mem_we` out 1: one-cycle write strobe.
- `mem_addr` out MEM_ADDR_W: word address.
- `mem_wdata` out 32: word data.
- `checksum` out 32: running additive checksum; present only with the macro (see Configuration).

## Operation
- States:
  - IDLE: on `start`, go to ISSUE, clear the sector and word counters, clear `done`, set `busy`.
  - ISSUE: drive `sd_address` = (BASE_SECTOR + sector_idx) << 9. When `sd_ready`=1, register `sd_rd`=1 for exactly one cycle and go to RECEIVE. Never assert `sd_rd` while `sd_ready`=0.
  - RECEIVE: each cycle with `sd_byte_available`=1, shift `sd_dout` into the word assembler. The first byte of a group of four lands in bits [31:24]. Count bytes 0..511 in a 9-bit counter. On byte 511, go to SETTLE.
  - SETTLE: wait for `sd_ready`=1, so the controller has returned to idle. Then:
    - if sector_idx == SECTOR_COUNT-1, go to IDLE, set `done`, clear `busy`;
    - otherwise increment sector_idx and go to ISSUE.
- Word emission: in the cycle after the 4th byte of a group is accepted, `mem_we`=1 with `mem_wdata` = the assembled word and `mem_addr` = sector_idx×128 + word_in_sector, truncated to MEM_ADDR_W (wraps silently).
- `mem_addr`/`mem_wdata` hold their last values when `mem_we`=0.
- `sd_byte_available` in IDLE, ISSUE or SETTLE is ignored; no write occurs.
- A `start` coinciding with the final SETTLE exit is ignored; `start` must arrive while in IDLE.
- Reset mid-run: next cycle is IDLE. The controller is reset alongside, so no pending-read cleanup is needed.
- Reset values: `sd_rd`=0, `sd_address`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `checksum`=0.

## Timing
- Latency `start` → `busy`: 1 cycle. `start` → first `sd_rd`: 2 cycles if `sd_ready` is already high.
- Byte → write latency: 1 cycle after the 4th byte. Strobes come no faster than every 4 bytes.
- Each sector produces exactly 128 `mem_we` pulses. Each run produces 128×SECTOR_COUNT pulses.
- Last `mem_we` → `done`: set at the SETTLE exit, no earlier than the cycle after the last `mem_we`.
- `sd_rd` is never high two consecutive cycles.

## Configuration
- `SD_BOOT_CHECKSUM_EN`:
  - Defined: `checksum` accumulates mem_wdata mod 2^32 on every `mem_we` cycle. It is cleared on accepted `start`, is stable from `done` onward, and is visible in the same cycle the write is visible.
  - Undefined: port is present but tied to 32'h0, and the accumulator is not built.

## Structure
- Shared package `sd_boot_pkg`:
  - state enum (IDLE, ISSUE, RECEIVE, SETTLE);
  - `SD_SECTOR_BYTES`=512, `SD_WORDS_PER_SECTOR`=128, `SD_SECTOR_SHIFT`=9.
- One sub-module, `sd_byte_packer`: 4-byte big-endian shift register with byte counter. It takes a byte valid and a byte in, and produces a registered word valid pulse and word out. It is cleared by reset and by accepted `start`.

## Test plan
- Single sector: SECTOR_COUNT=1; model streams bytes 00 00 00 0F, 80 40 00 0F, then 00. Expect:
  - `mem_we` at addr 0 with 32'h0000000F;
  - `mem_we` at addr 1 with 32'h8040000F;
  - 128 writes total, then `done`=1 and `busy`=0.
- Multi-sector addressing: SECTOR_COUNT=2, BASE_SECTOR=3. Expect:
  - `sd_address` = 32'h600 on the first `sd_rd` and 32'h800 on the second;
  - first word of the second sector written at `mem_addr`=128.
- Handshake: hold `sd_ready`=0 for 20 cycles in ISSUE. Expect no `sd_rd`; exactly one `sd_rd` pulse the cycle after `sd_ready` rises.
- Reset mid-run: reset after byte 200 of sector 0. Expect:
  - IDLE next cycle with all outputs at reset values;
  - a fresh `start` restarts at `mem_addr`=0.
- Start while busy: pulse `start` during RECEIVE. Expect no restart, unchanged counters and an identical write sequence.
- `SD_BOOT_CHECKSUM_EN` defined: all-0x01 sector. Expect `checksum` = 128×32'h01010101 = 32'h80808080 at `done`.

Source files
------------

// File: rtl/sd_boot_pkg.sv
// sd_boot_pkg
// Shared types and constants for the SD-card boot loader.
//   state_t          : sequencer states (IDLE, ISSUE, RECEIVE, SETTLE)
//   SD_SECTOR_BYTES  : bytes per SD sector
//   SD_WORDS_PER_SECTOR : 32-bit words per sector
//   SD_SECTOR_SHIFT  : log2 of the sector size, sector index -> byte address
//   sector_byte_addr : byte address of sector (base + idx)
package sd_boot_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RECEIVE = 2'd2,
        SETTLE  = 2'd3
    } state_t;

    localparam int SD_SECTOR_BYTES     = 512;
    localparam int SD_WORDS_PER_SECTOR = 128;
    localparam int SD_SECTOR_SHIFT     = 9;

    function automatic logic [31:0] sector_byte_addr(input logic [31:0] base,
                                                     input logic [15:0] idx);
        return (base + {16'd0, idx}) << SD_SECTOR_SHIFT;
    endfunction

endpackage

// File: rtl/sd_byte_packer.sv
// sd_byte_packer
// Packs a byte stream big-endian into 32-bit words. The first byte of each
// group of four ends up in bits [31:24]. A registered one-cycle word valid
// pulse follows the cycle in which the 4th byte is accepted; the word output
// holds its value between pulses.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   i_clear        : restart packing (accepted start), drops any partial word
//   i_byte_vld     : i_byte is valid this cycle
//   i_byte         : incoming byte
//   o_word_vld     : one-cycle pulse, o_word is a freshly completed word
//   o_word         : last completed word
module sd_byte_packer
    import sd_boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte,
    output logic        o_word_vld,
    output logic [31:0] o_word
);

    // Only the three older bytes need storing; the 4th comes straight from i_byte.
    logic [23:0] r_shift;
    logic [1:0]  r_cnt;
    logic        r_word_vld;
    logic [31:0] r_word;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_shift    <= 24'd0;
            r_cnt      <= 2'd0;
            r_word_vld <= 1'b0;
            if (reset) begin
                r_word <= 32'd0;
            end
        end else begin
            r_word_vld <= 1'b0;
            if (i_byte_vld) begin
                r_shift <= {r_shift[15:0], i_byte};
                r_cnt   <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    r_word_vld <= 1'b1;
                    r_word     <= {r_shift, i_byte};
                end
            end
        end
    end

    assign o_word_vld = r_word_vld;
    assign o_word     = r_word;

endmodule

// File: rtl/sd_boot_loader.sv
// sd_boot_loader
// Copies SECTOR_COUNT consecutive 512-byte sectors, starting at BASE_SECTOR,
// from the SD byte-read controller into word-addressed program memory, one
// sector read at a time. Holds the CPU in reset through busy.
// Optional feature macro: SD_BOOT_CHECKSUM_EN (running additive checksum of
// all written words; without it the checksum port reads 0).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : one-cycle run request, honoured only in IDLE
//   busy              : run in progress
//   done              : sticky, last word of the run written
//   sd_ready          : controller idle, may accept sd_rd
//   sd_rd             : one-cycle sector read request
//   sd_address        : sector byte address (multiple of 512)
//   sd_dout           : byte from controller
//   sd_byte_available : sd_dout valid this cycle
//   mem_we            : one-cycle memory write strobe
//   mem_addr          : memory word address (wraps at MEM_ADDR_W)
//   mem_wdata         : memory write data
//   checksum          : running sum of written words (mod 2^32)
module sd_boot_loader
    import sd_boot_pkg::*;
#(
    parameter int SECTOR_COUNT = 8,
    parameter int BASE_SECTOR  = 0,
    parameter int MEM_ADDR_W   = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  sd_ready,
    output logic                  sd_rd,
    output logic [31:0]           sd_address,
    input  logic [7:0]            sd_dout,
    input  logic                  sd_byte_available,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [31:0]           checksum
);

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_sd_rd;
    logic [31:0]           r_sd_address;
    logic [15:0]           r_sector;
    logic [8:0]            r_byte_cnt;
    logic [MEM_ADDR_W-1:0] r_mem_addr;

    logic                  w_start_acc;
    logic                  w_byte_vld;
    logic                  w_word_vld;
    logic [31:0]           w_word;

    assign w_start_acc = start && (r_state == IDLE);
    // Bytes outside RECEIVE are stray and must never reach the packer.
    assign w_byte_vld  = sd_byte_available && (r_state == RECEIVE);

    sd_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_start_acc),
        .i_byte_vld (w_byte_vld),
        .i_byte     (sd_dout),
        .o_word_vld (w_word_vld),
        .o_word     (w_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sd_rd      <= 1'b0;
            r_sd_address <= 32'd0;
            r_sector     <= 16'd0;
            r_byte_cnt   <= 9'd0;
            r_mem_addr   <= '0;
        end else begin
            r_sd_rd <= 1'b0;

            // Address is latched alongside the 4th byte so it lines up with
            // the packer's registered word strobe.
            if (w_byte_vld && (r_byte_cnt[1:0] == 2'd3)) begin
                r_mem_addr <= MEM_ADDR_W'(32'(r_sector) * 32'(SD_WORDS_PER_SECTOR)
                                          + 32'(r_byte_cnt[8:2]));
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state      <= ISSUE;
                        r_sector     <= 16'd0;
                        r_byte_cnt   <= 9'd0;
                        r_done       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_sd_address <= sector_byte_addr(32'(BASE_SECTOR), 16'd0);
                    end
                end
                ISSUE: begin
                    if (sd_ready) begin
                        r_sd_rd <= 1'b1;
                        r_state <= RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (sd_byte_available) begin
                        // 9-bit counter wraps to 0 on the last byte, ready for the next sector.
                        r_byte_cnt <= r_byte_cnt + 9'd1;
                        if (r_byte_cnt == 9'(SD_SECTOR_BYTES - 1)) begin
                            r_state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (sd_ready) begin
                        if (r_sector == 16'(SECTOR_COUNT - 1)) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_sector     <= r_sector + 16'd1;
                            r_sd_address <= sector_byte_addr(32'(BASE_SECTOR),
                                                             r_sector + 16'd1);
                            r_state      <= ISSUE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SD_BOOT_CHECKSUM_EN
    logic [31:0] r_cks_acc;

    always_ff @(posedge clk) begin
        if (reset || w_start_acc) begin
            r_cks_acc <= 32'd0;
        end else if (w_word_vld) begin
            r_cks_acc <= r_cks_acc + w_word;
        end
    end

    // Include the word being written so the sum is current in the strobe cycle.
    assign checksum = r_cks_acc + (w_word_vld ? w_word : 32'd0);
`else
    assign checksum = 32'h0;
`endif

    assign busy       = r_busy;
    assign done       = r_done;
    assign sd_rd      = r_sd_rd;
    assign sd_address = r_sd_address;
    assign mem_we     = w_word_vld;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = w_word;

endmodule

// File: tb/tb_sd_boot_loader.sv
// Bench for sd_boot_loader (SECTOR_COUNT=2, BASE_SECTOR=3, MEM_ADDR_W=12).
// A behavioural SD controller streams a selectable byte pattern; the main
// sequence checks reset values, timing, handshakes, addresses, data,
// stray-byte rejection, start-while-busy, mid-run reset and checksum.
module tb_sd_boot_loader;

    localparam int SC = 2;
    localparam int BS = 3;
    localparam int AW = 12;

`ifdef SD_BOOT_CHECKSUM_EN
    localparam bit CKS_ON = 1'b1;
`else
    localparam bit CKS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          sd_ready;
    logic          sd_rd;
    logic [31:0]   sd_address;
    logic [7:0]    sd_dout;
    logic          sd_byte_available;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   checksum;

    sd_boot_loader #(.SECTOR_COUNT(SC), .BASE_SECTOR(BS), .MEM_ADDR_W(AW)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .sd_ready          (sd_ready),
        .sd_rd             (sd_rd),
        .sd_address        (sd_address),
        .sd_dout           (sd_dout),
        .sd_byte_available (sd_byte_available),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .checksum          (checksum)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Controller model knobs (written by the main sequence only).
    int m_mode  = 0;
    bit m_hold  = 1'b0;
    bit m_gap   = 1'b0;
    bit m_stray = 1'b0;
    int m_g     = 0;     // bytes streamed in the current run (model-owned)

    // Monitor state (main sequence only).
    int          n_wr = 0;
    int          n_rd = 0;
    logic [31:0] exp_sum = 32'd0;
    logic [31:0] w0 = 32'd0, w1 = 32'd0, a0 = 32'hFFFF_FFFF, a128 = 32'd0;
    logic        p_busy = 1'b0, p_ready = 1'b0, p_rd = 1'b0;

    // mode 0: 00 00 00 0F 80 40 00 0F then 00; mode 1: all 01; mode 2: varied.
    function automatic logic [7:0] pat(input int mode, input int g);
        logic [63:0] t;
        t = 64'h0000000F_8040000F;
        case (mode)
            0:       pat = (g < 8) ? t[63 - 8*g -: 8] : 8'h00;
            1:       pat = 8'h01;
            default: pat = 8'(g * 37 + (g >> 9) * 11 + 5);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check every write/read seen there.
    task automatic tick();
        logic [31:0] ew;
        int g;
        @(negedge clk);
        if (busy === 1'b1 && p_busy === 1'b0) begin
            n_wr = 0; n_rd = 0; exp_sum = 32'd0; a0 = 32'hFFFF_FFFF;
        end
        if (mem_we === 1'b1) begin
            g  = n_wr * 4;
            ew = {pat(m_mode, g), pat(m_mode, g + 1), pat(m_mode, g + 2), pat(m_mode, g + 3)};
            chk("wr_addr", 32'(mem_addr), 32'(n_wr % 4096));
            chk("wr_data", mem_wdata, ew);
            exp_sum = exp_sum + ew;
            if (CKS_ON) chk("cks_live", checksum, exp_sum);
            if (n_wr == 0)   begin w0 = mem_wdata; a0 = 32'(mem_addr); end
            if (n_wr == 1)   w1 = mem_wdata;
            if (n_wr == 128) a128 = 32'(mem_addr);
            n_wr++;
        end
        if (sd_rd === 1'b1) begin
            chk("rd_addr", sd_address, 32'((BS + n_rd) << 9));
            chk("rd_ready", 32'(p_ready), 32'd1);
            chk("rd_double", 32'(p_rd), 32'd0);
            n_rd++;
        end
        p_busy  = busy;
        p_ready = sd_ready;
        p_rd    = sd_rd;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 6000 && done !== 1'b1; i++) tick();
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_bytes(input string tag, input int nb);
        for (int i = 0; i < 3000 && m_g < nb; i++) tick();
        chk(tag, 32'(m_g >= nb), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string sfx);
        chk({"rst_busy", sfx},  32'(busy), 32'd0);
        chk({"rst_done", sfx},  32'(done), 32'd0);
        chk({"rst_sdrd", sfx},  32'(sd_rd), 32'd0);
        chk({"rst_sdadr", sfx}, sd_address, 32'd0);
        chk({"rst_we", sfx},    32'(mem_we), 32'd0);
        chk({"rst_maddr", sfx}, 32'(mem_addr), 32'd0);
        chk({"rst_wdata", sfx}, mem_wdata, 32'd0);
        chk({"rst_cks", sfx},   checksum, 32'd0);
    endtask

    // Behavioural SD controller: 3-cycle latency after sd_rd, 512 bytes
    // (optionally every other cycle), then 2 busy cycles before ready.
    initial begin
        int ms, cnt, k;
        bit pb, tog;
        ms = 0; cnt = 0; k = 0; pb = 1'b0; tog = 1'b0;
        sd_ready = 1'b1; sd_byte_available = 1'b0; sd_dout = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1) begin
                ms = 0;
                sd_ready = !m_hold; sd_byte_available = m_stray; sd_dout = 8'hFF;
            end else begin
                if (!pb) begin ms = 0; m_g = 0; end
                case (ms)
                    0: begin
                        sd_ready = !m_hold; sd_byte_available = m_stray; sd_dout = 8'hFF;
                        if (sd_rd === 1'b1) begin
                            ms = 1; cnt = 3; sd_ready = 1'b0; sd_byte_available = 1'b0;
                        end
                    end
                    1: begin
                        sd_ready = 1'b0; sd_byte_available = 1'b0;
                        cnt--;
                        if (cnt == 0) begin ms = 2; k = 0; tog = 1'b0; end
                    end
                    2: begin
                        sd_ready = 1'b0;
                        tog = !tog;
                        if (m_gap && !tog) begin
                            sd_byte_available = 1'b0;
                        end else begin
                            sd_byte_available = 1'b1;
                            sd_dout = pat(m_mode, m_g);
                            m_g++; k++;
                            if (k == 512) begin ms = 3; cnt = 2; end
                        end
                    end
                    default: begin
                        sd_ready = 1'b0; sd_byte_available = m_stray; sd_dout = 8'hFF;
                        cnt--;
                        if (cnt == 0) ms = 0;
                    end
                endcase
            end
            pb = (busy === 1'b1);
        end
    end

    initial begin
        logic [31:0] cks_hold;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        chk_reset_vals("_init");
        reset = 1'b0;
        tick();

        // Run A: table pattern, start timing, addressing, first words.
        m_mode = 0;
        start = 1'b1;
        tick();
        chk("start_busy_lat", 32'(busy), 32'd1);
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_no_rd_yet", 32'(sd_rd), 32'd0);
        start = 1'b0;
        tick();
        chk("first_rd_lat", 32'(sd_rd), 32'd1);
        chk("first_rd_adr", sd_address, 32'h0000_0600);
        wait_done("runA_done");
        chk("runA_busy", 32'(busy), 32'd0);
        chk("runA_nwr", 32'(n_wr), 32'd256);
        chk("runA_nrd", 32'(n_rd), 32'd2);
        chk("runA_w0", w0, 32'h0000_000F);
        chk("runA_w1", w1, 32'h8040_000F);
        chk("runA_a128", a128, 32'd128);
        chk("runA_cks", checksum, CKS_ON ? 32'h8040_001E : 32'h0);

        // Stray bytes while idle are ignored.
        m_stray = 1'b1;
        repeat (10) tick();
        m_stray = 1'b0;
        chk("stray_idle_nowr", 32'(n_wr), 32'd256);
        chk("done_sticky", 32'(done), 32'd1);

        // Run B: ready held low in ISSUE, gapped stream, stray bytes, start while busy.
        m_mode = 2; m_gap = 1'b1; m_stray = 1'b1; m_hold = 1'b1;
        repeat (2) tick();
        pulse_start();
        chk("runB_busy", 32'(busy), 32'd1);
        chk("runB_done_clr", 32'(done), 32'd0);
        repeat (20) tick();
        chk("hold_no_rd", 32'(n_rd), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
        m_hold = 1'b0;
        tick();
        chk("rel_ready", 32'(sd_ready), 32'd1);
        chk("rel_rd_not_yet", 32'(sd_rd), 32'd0);
        tick();
        chk("rel_rd_pulse", 32'(sd_rd), 32'd1);
        tick();
        chk("rel_rd_single", 32'(sd_rd), 32'd0);
        chk("rel_nrd", 32'(n_rd), 32'd1);
        wait_bytes("runB_reach100", 100);
        pulse_start();
        chk("sbusy_busy", 32'(busy), 32'd1);
        chk("sbusy_nrd", 32'(n_rd), 32'd1);
        wait_done("runB_done");
        chk("runB_nwr", 32'(n_wr), 32'd256);
        chk("runB_nrd", 32'(n_rd), 32'd2);
        chk("runB_cks", checksum, CKS_ON ? exp_sum : 32'h0);
        m_gap = 1'b0; m_stray = 1'b0;
        tick();

        // Run C: reset after byte 200 of sector 0, then a clean restart.
        m_mode = 2;
        pulse_start();
        wait_bytes("runC_reach201", 201);
        reset = 1'b1;
        tick();
        chk_reset_vals("_mid");
        reset = 1'b0;
        repeat (3) tick();
        chk("mid_idle_busy", 32'(busy), 32'd0);
        pulse_start();
        wait_done("runC_done");
        chk("restart_a0", a0, 32'd0);
        chk("runC_nwr", 32'(n_wr), 32'd256);

        // Run D: all-0x01 data, checksum over 256 words.
        m_mode = 1;
        tick();
        pulse_start();
        wait_done("runD_done");
        chk("runD_nwr", 32'(n_wr), 32'd256);
        chk("runD_cks", checksum, CKS_ON ? 32'h0101_0100 : 32'h0);
        cks_hold = checksum;
        repeat (5) tick();
        chk("runD_cks_stable", checksum, cks_hold);
        chk("runD_done_hold", 32'(done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
